// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-lite encodings for masters and slaves on the generated interconnect.
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'b000,
    HSIZE_HWORD = 3'b001,
    HSIZE_WORD  = 3'b010
  } hsize_e;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_OKAY    = 1'b0;
  localparam logic       HRESP_ERROR   = 1'b1;

  // Only byte/half/word transfers exist on a 32-bit bus; larger encodings fold to word.
  function automatic logic [2:0] clamp_size(logic [2:0] s);
    return (s > HSIZE_WORD) ? HSIZE_WORD : s;
  endfunction

endpackage

// File: rtl/ahb3lite_cmd_master_if.sv
// Command stream plus AHB3-lite master-side bus bundle for ahb3lite_cmd_master.
interface ahb3lite_cmd_master_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) ();
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [HADDR_SIZE-1:0] cmd_addr;
  logic [2:0]            cmd_size;
  logic [HDATA_SIZE-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_err;
  logic [HDATA_SIZE-1:0] rsp_rdata;
  logic                  busy;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic [1:0]            HTRANS;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic                  HWRITE;
  logic                  HMASTLOCK;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HRESP;
  logic                  HREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HRDATA, HRESP, HREADY,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           HADDR, HWDATA, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HMASTLOCK
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HRDATA, HRESP, HREADY,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy,
           HADDR, HWDATA, HTRANS, HSIZE, HBURST, HPROT, HWRITE, HMASTLOCK
  );
endinterface

// File: rtl/ahb3lite_cmd_master.sv
// Valid/ready command stream to pipelined single AHB3-lite transfers, one response per command.
module ahb3lite_cmd_master
  import ahb3lite_pkg::*;
#(
  parameter int         HADDR_SIZE = 32,
  parameter int         HDATA_SIZE = 32,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input logic                   CLK,
  input logic                   RESET,
  ahb3lite_cmd_master_if.master bus
);

  logic                  a_vld_q, a_vld_d;
  logic                  d_vld_q, d_vld_d;
  logic                  cancel_q, cancel_d;
  logic                  hwrite_q, hwrite_d;
  logic                  d_write_q, d_write_d;
  logic [2:0]            hsize_q, hsize_d;
  logic [HADDR_SIZE-1:0] haddr_q, haddr_d;
  logic [HDATA_SIZE-1:0] wdata_q, wdata_d;
  logic [HDATA_SIZE-1:0] hwdata_q, hwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  accept, advance;
  logic [2:0]            size_eff;
  logic [HADDR_SIZE-1:0] addr_algn;

  always_comb begin
    size_eff  = clamp_size(bus.cmd_size);
    addr_algn = bus.cmd_addr;
    case (size_eff)
      HSIZE_HWORD: addr_algn[0]   = 1'b0;
      HSIZE_WORD:  addr_algn[1:0] = 2'b00;
      default: ;
    endcase
  end

  // While cancelling after an ERROR the address phase must not be consumed by the slave.
  assign bus.cmd_ready = !a_vld_q || (bus.HREADY && !cancel_q);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign advance       = bus.HREADY && a_vld_q && !cancel_q;

  always_comb begin
    a_vld_d     = a_vld_q;
    d_vld_d     = d_vld_q;
    cancel_d    = cancel_q;
    hwrite_d    = hwrite_q;
    d_write_d   = d_write_q;
    hsize_d     = hsize_q;
    haddr_d     = haddr_q;
    wdata_d     = wdata_q;
    hwdata_d    = hwdata_q;
    rsp_rdata_d = rsp_rdata_q;

    if (advance) begin
      d_vld_d   = 1'b1;
      d_write_d = hwrite_q;
      if (hwrite_q) hwdata_d = wdata_q;
    end else if (bus.HREADY) begin
      d_vld_d = 1'b0;
    end

    if (accept) begin
      a_vld_d  = 1'b1;
      haddr_d  = addr_algn;
      hwrite_d = bus.cmd_write;
      hsize_d  = size_eff;
      wdata_d  = bus.cmd_wdata;
    end else if (advance) begin
      a_vld_d = 1'b0;
    end

    // First ERROR cycle arms the cancel; the completing (HREADY) cycle ends it.
    if (bus.HREADY)                       cancel_d = 1'b0;
    else if (d_vld_q && bus.HRESP)        cancel_d = 1'b1;

    rsp_valid_d = d_vld_q && bus.HREADY;
    rsp_err_d   = rsp_valid_d ? bus.HRESP : 1'b0;
    if (rsp_valid_d) rsp_rdata_d = d_write_q ? '0 : bus.HRDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      a_vld_q     <= 1'b0;
      d_vld_q     <= 1'b0;
      cancel_q    <= 1'b0;
      hwrite_q    <= 1'b0;
      d_write_q   <= 1'b0;
      hsize_q     <= '0;
      haddr_q     <= '0;
      wdata_q     <= '0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      a_vld_q     <= a_vld_d;
      d_vld_q     <= d_vld_d;
      cancel_q    <= cancel_d;
      hwrite_q    <= hwrite_d;
      d_write_q   <= d_write_d;
      hsize_q     <= hsize_d;
      haddr_q     <= haddr_d;
      wdata_q     <= wdata_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.HTRANS    = (a_vld_q && !cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.HADDR     = haddr_q;
  assign bus.HWDATA    = hwdata_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HSIZE     = hsize_q;
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = a_vld_q || d_vld_q;

endmodule
